// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the two-master memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int AW_DEF      = 32;
    localparam int DW_DEF      = 32;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GNT0 = 3'd1,
        ST_GNT1 = 3'd2,
        ST_TURN = 3'd3,
        ST_ERR  = 3'd4
    } arb_state_e;

    function automatic int wdog_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// One master<->slave bus link: request side plus per-beat ack, read data and abort.
interface mem_bus_arbiter_if
    import mem_bus_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          cyc;
    logic          we;
    logic [3:0]    strb;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_o;
    logic [DW-1:0] data_i;
    logic          ack;
    logic          err;

    modport master (output cyc, we, strb, addr, data_o, input ack, data_i, err);
    modport slave  (input cyc, we, strb, addr, data_o, output ack, data_i, err);
endinterface

// File: rtl/mem_bus_arbiter_wdog.sv
// Per-beat ack watchdog: counts stalled cycles while enabled, flags the last allowed one.
module mem_bus_arbiter_wdog
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int            W    = wdog_width(TIMEOUT);
    localparam logic [W-1:0]  LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = en && (cnt == LAST);
endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin two-master arbiter with grant locked for the whole cyc window and an ack watchdog.
//
//  state | meaning
//  IDLE  | bus free, arbitrate pending requests
//  GNT0  | MMU (m0) owns the bus
//  GNT1  | DMA (m1) owns the bus
//  TURN  | one dead bus cycle between owners
//  ERR   | watchdog abort, err pulse to the owner
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    mem_bus_arbiter_if.slave          m0,
    mem_bus_arbiter_if.slave          m1,
    mem_bus_arbiter_if.master         s,
    output logic [1:0]                gnt
);
    arb_state_e state;
    logic       last_gnt;
    logic       err0;
    logic       err1;
    logic       expire;
    logic       in_gnt;

    assign in_gnt = (state == ST_GNT0) || (state == ST_GNT1);

    mem_bus_arbiter_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (!in_gnt || s.ack),
        .en     (in_gnt),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt      <= 2'b00;
            last_gnt <= 1'b1;
            err0     <= 1'b0;
            err1     <= 1'b0;
        end else begin
            err0 <= 1'b0;
            err1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // on a tie, the master that did not own the bus last wins
                    if (m0.cyc && (!m1.cyc || last_gnt)) begin
                        state    <= ST_GNT0;
                        gnt      <= 2'b01;
                        last_gnt <= 1'b0;
                    end else if (m1.cyc) begin
                        state    <= ST_GNT1;
                        gnt      <= 2'b10;
                        last_gnt <= 1'b1;
                    end
                end
                ST_GNT0: begin
                    if (!m0.cyc) begin
                        state <= ST_TURN;
                        gnt   <= 2'b00;
                    end else if (expire && !s.ack) begin
                        state <= ST_ERR;
                        gnt   <= 2'b00;
                        err0  <= 1'b1;
                    end
                end
                ST_GNT1: begin
                    if (!m1.cyc) begin
                        state <= ST_TURN;
                        gnt   <= 2'b00;
                    end else if (expire && !s.ack) begin
                        state <= ST_ERR;
                        gnt   <= 2'b00;
                        err1  <= 1'b1;
                    end
                end
                ST_ERR:  state <= ST_TURN;
                ST_TURN: state <= ST_IDLE;
                default: begin
                    state <= ST_IDLE;
                    gnt   <= 2'b00;
                end
            endcase
        end
    end

    // gnt is nonzero only in GNTx, so the slave side is idle in every other state
    always_comb begin
        s.cyc    = 1'b0;
        s.we     = 1'b0;
        s.strb   = 4'h0;
        s.addr   = {AW{1'b0}};
        s.data_o = {DW{1'b0}};
        if (gnt[0]) begin
            s.cyc    = m0.cyc;
            s.we     = m0.we;
            s.strb   = m0.strb;
            s.addr   = m0.addr;
            s.data_o = m0.data_o;
        end else if (gnt[1]) begin
            s.cyc    = m1.cyc;
            s.we     = m1.we;
            s.strb   = m1.strb;
            s.addr   = m1.addr;
            s.data_o = m1.data_o;
        end
    end

    assign m0.ack    = s.ack & gnt[0] & (state == ST_GNT0);
    assign m1.ack    = s.ack & gnt[1] & (state == ST_GNT1);
    assign m0.data_i = gnt[0] ? s.data_i : {DW{1'b0}};
    assign m1.data_i = gnt[1] ? s.data_i : {DW{1'b0}};
    assign m0.err    = err0;
    assign m1.err    = err1;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: grants, bursts, round-robin, watchdog and async reset.
module tb_mem_bus_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] gnt;
    int         n_tests = 0;
    int         n_fail  = 0;
    logic       saw_err;
    logic       saw_ack;

    mem_bus_arbiter_if #(.AW(32), .DW(32)) m0_bus ();
    mem_bus_arbiter_if #(.AW(32), .DW(32)) m1_bus ();
    mem_bus_arbiter_if #(.AW(32), .DW(32)) s_bus ();

    mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(64)) dut (
        .clk (clk),
        .rst (rst),
        .m0  (m0_bus),
        .m1  (m1_bus),
        .s   (s_bus),
        .gnt (gnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        m0_bus.cyc = 0; m0_bus.we = 0; m0_bus.strb = 0; m0_bus.addr = 0; m0_bus.data_o = 0;
        m1_bus.cyc = 0; m1_bus.we = 0; m1_bus.strb = 0; m1_bus.addr = 0; m1_bus.data_o = 0;
        s_bus.ack = 0; s_bus.data_i = 0; s_bus.err = 0;
    endtask

    initial begin
        // reset with every input high
        rst = 1'b1;
        m0_bus.cyc = 1; m0_bus.we = 1; m0_bus.strb = 4'hF; m0_bus.addr = '1; m0_bus.data_o = '1;
        m1_bus.cyc = 1; m1_bus.we = 1; m1_bus.strb = 4'hF; m1_bus.addr = '1; m1_bus.data_o = '1;
        s_bus.ack = 1; s_bus.data_i = '1; s_bus.err = 0;
        #12;
        chk("rst_gnt",     gnt,            0);
        chk("rst_s_cyc",   s_bus.cyc,      0);
        chk("rst_s_addr",  s_bus.addr,     0);
        chk("rst_s_data",  s_bus.data_o,   0);
        chk("rst_m0_ack",  m0_bus.ack,     0);
        chk("rst_m1_ack",  m1_bus.ack,     0);
        chk("rst_m0_rd",   m0_bus.data_i,  0);
        chk("rst_m1_err",  m1_bus.err,     0);

        clear_inputs();
        m0_bus.cyc  = 1;
        m0_bus.addr = 32'h1234_5678;
        #1 rst = 1'b0;
        tick();
        chk("t1_gnt",    gnt,        2'b01);
        chk("t1_s_cyc",  s_bus.cyc,  1);
        chk("t1_s_addr", s_bus.addr, 32'h1234_5678);

        // 8-beat m0 read, m1 requests at beat 2
        for (int b = 0; b < 8; b++) begin
            s_bus.ack    = 1;
            s_bus.data_i = 32'h1000 + b;
            if (b == 2) begin
                m1_bus.cyc  = 1;
                m1_bus.addr = 32'hA000_0000;
            end
            #1;
            chk($sformatf("t2_m0_ack_b%0d", b), m0_bus.ack,    1);
            chk($sformatf("t2_m0_rd_b%0d", b),  m0_bus.data_i, 32'h1000 + b);
            chk($sformatf("t2_m1_ack_b%0d", b), m1_bus.ack,    0);
            tick();
        end
        s_bus.ack  = 0;
        m0_bus.cyc = 0;
        #1;
        chk("t2_drop_s_cyc", s_bus.cyc, 0);
        chk("t2_drop_gnt",   gnt,       2'b01);
        tick();
        chk("t2_turn_gnt",   gnt,       2'b00);
        chk("t2_turn_s_cyc", s_bus.cyc, 0);
        tick();
        chk("t2_idle_gnt",   gnt,       2'b00);
        tick();
        chk("t2_m1_gnt",     gnt,       2'b10);
        chk("t2_m1_addr",    s_bus.addr, 32'hA000_0000);
        m1_bus.cyc = 0;
        tick(2);

        // round-robin from reset with simultaneous requests
        clear_inputs();
        rst = 1'b1;
        #2 rst = 1'b0;
        for (int r = 0; r < 4; r++) begin
            m0_bus.cyc = 1;
            m1_bus.cyc = 1;
            tick();
            chk($sformatf("t3_rr_r%0d", r), gnt, (r % 2 == 0) ? 64'd1 : 64'd2);
            m0_bus.cyc = 0;
            m1_bus.cyc = 0;
            tick(2);
        end

        // watchdog abort on m1
        m1_bus.cyc = 1;
        tick();
        chk("t4_gnt", gnt, 2'b10);
        saw_err = 0;
        saw_ack = 0;
        for (int c = 1; c < 64; c++) begin
            tick();
            saw_err = saw_err | m0_bus.err | m1_bus.err;
            saw_ack = saw_ack | m1_bus.ack;
        end
        chk("t4_no_early_err", saw_err,   0);
        chk("t4_no_ack",       saw_ack,   0);
        chk("t4_c63_s_cyc",    s_bus.cyc, 1);
        tick();
        chk("t4_err_pulse",    m1_bus.err, 1);
        chk("t4_err_s_cyc",    s_bus.cyc,  0);
        chk("t4_err_gnt",      gnt,        2'b00);
        tick();
        chk("t4_turn_err",     m1_bus.err, 0);
        chk("t4_turn_s_cyc",   s_bus.cyc,  0);
        tick(2);
        chk("t4_regrant",      gnt,        2'b10);
        m1_bus.cyc = 0;
        tick(2);

        // ack on the last watchdog cycle wins; ack in TURN is dropped
        m0_bus.cyc = 1;
        tick();
        chk("t5_gnt", gnt, 2'b01);
        tick(63);
        s_bus.ack    = 1;
        s_bus.data_i = 32'hBEEF;
        #1;
        chk("t5_last_ack", m0_bus.ack,    1);
        chk("t5_last_rd",  m0_bus.data_i, 32'hBEEF);
        tick();
        chk("t5_no_err",   m0_bus.err,    0);
        chk("t5_hold_gnt", gnt,           2'b01);
        m0_bus.cyc = 0;
        #1;
        chk("t5_rel_ack",  m0_bus.ack,    1);
        tick();
        chk("t5_turn_m0_ack", m0_bus.ack, 0);
        chk("t5_turn_m1_ack", m1_bus.ack, 0);
        chk("t5_turn_gnt",    gnt,        2'b00);
        tick();
        s_bus.ack = 0;

        // async reset mid-burst
        m0_bus.cyc = 1;
        tick();
        for (int b = 0; b < 3; b++) begin
            s_bus.ack = 1;
            tick();
        end
        #1;
        chk("t6_beat3_ack", m0_bus.ack, 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_s_cyc",  s_bus.cyc,  0);
        chk("t6_rst_gnt",    gnt,        2'b00);
        chk("t6_rst_m0_ack", m0_bus.ack, 0);
        #2;
        rst       = 1'b0;
        s_bus.ack = 0;
        tick();
        chk("t6_regrant",    gnt,        2'b01);
        chk("t6_re_s_cyc",   s_bus.cyc,  1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
